// File: rtl/bn_pkg.sv
// Shared sizing and types for the batch-norm global statistics scheduler.
package bn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int MINI_BATCH = 64;
  localparam int ADDR_WIDTH = $clog2(MINI_BATCH);
  localparam int NUM_CH     = 16;
  localparam int CH_WIDTH   = $clog2(NUM_CH);
  localparam int NUM_REQ    = 4;
  localparam int REQ_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_e;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] avg;
    logic signed [DATA_WIDTH-1:0] variance;
    logic                         seeded;
  } entry_t;

endpackage

// File: rtl/upd_sched_if.sv
// Requester, done, clear and table-read signals of upd_sched.
interface upd_sched_if;
  import bn_pkg::*;

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*CH_WIDTH-1:0]   req_ch;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_avg;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_var;
  logic                          clr;
  logic                          busy;
  logic                          done_valid;
  logic [REQ_WIDTH-1:0]          done_req;
  logic [CH_WIDTH-1:0]           done_ch;
  logic signed [DATA_WIDTH-1:0]  done_avg;
  logic signed [DATA_WIDTH-1:0]  done_var;
  logic [CH_WIDTH-1:0]           rd_ch;
  logic signed [DATA_WIDTH-1:0]  rd_avg;
  logic signed [DATA_WIDTH-1:0]  rd_var;

  modport master (
    output req_valid, req_ch, req_avg, req_var, clr, rd_ch,
    input  req_ready, busy, done_valid, done_req, done_ch, done_avg, done_var,
           rd_avg, rd_var
  );

  modport slave (
    input  req_valid, req_ch, req_avg, req_var, clr, rd_ch,
    output req_ready, busy, done_valid, done_req, done_ch, done_avg, done_var,
           rd_avg, rd_var
  );

endinterface

// File: rtl/upd_alu.sv
// Running-average update of one statistic field; an unseeded entry takes the sample as is.
module upd_alu
  import bn_pkg::*;
(
  input  logic                         seeded,
  input  logic signed [DATA_WIDTH-1:0] g_old,
  input  logic signed [DATA_WIDTH-1:0] s,
  output logic signed [DATA_WIDTH-1:0] g_new
);

  localparam int PW = DATA_WIDTH + ADDR_WIDTH;

  logic signed [PW-1:0]         g_ext_s;
  logic signed [PW-1:0]         prod_s;
  logic signed [DATA_WIDTH-1:0] prod_sh_s;
  logic signed [DATA_WIDTH-1:0] s_sh_s;

  // Each term is floored on its own before the wrapping sum.
  always_comb begin
    g_ext_s   = {{ADDR_WIDTH{g_old[DATA_WIDTH-1]}}, g_old};
    prod_s    = g_ext_s * $signed(PW'(MINI_BATCH - 1));
    prod_sh_s = DATA_WIDTH'(prod_s >>> ADDR_WIDTH);
    s_sh_s    = s >>> ADDR_WIDTH;
    if (seeded) begin
      g_new = prod_sh_s + s_sh_s;
    end else begin
      g_new = s;
    end
  end

endmodule

// File: rtl/upd_sched.sv
// Round-robin scheduler that read-modify-writes the per-channel global avg/var table.
module upd_sched
  import bn_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  upd_sched_if.slave bus
);

  state_e                       state_q, state_d;
  logic [REQ_WIDTH-1:0]         ptr_q, ptr_d;
  logic                         ex_valid_q, ex_valid_d;
  logic [REQ_WIDTH-1:0]         ex_req_q, ex_req_d;
  logic [CH_WIDTH-1:0]          ex_ch_q, ex_ch_d;
  logic signed [DATA_WIDTH-1:0] ex_avg_q, ex_avg_d, ex_var_q, ex_var_d;
  entry_t                       table_q [NUM_CH];
  entry_t                       table_d [NUM_CH];
  logic                         done_valid_q, done_valid_d;
  logic [REQ_WIDTH-1:0]         done_req_q, done_req_d;
  logic [CH_WIDTH-1:0]          done_ch_q, done_ch_d;
  logic signed [DATA_WIDTH-1:0] done_avg_q, done_avg_d, done_var_q, done_var_d;
  logic signed [DATA_WIDTH-1:0] rd_avg_q, rd_avg_d, rd_var_q, rd_var_d;

  logic [REQ_WIDTH-1:0]         grant_s, idx_s;
  logic                         found_s, hit_s, accept_s;
  logic [NUM_REQ-1:0]           req_ready_s;
  entry_t                       old_s;
  logic signed [DATA_WIDTH-1:0] new_avg_s, new_var_s;

  // First valid requester at or after ptr_q wins; clr or a non-RUN state blocks accepts.
  always_comb begin
    grant_s = ptr_q;
    found_s = 1'b0;
    idx_s   = '0;
    hit_s   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_s   = REQ_WIDTH'((int'(ptr_q) + k) % NUM_REQ);
      hit_s   = !found_s && bus.req_valid[idx_s];
      grant_s = hit_s ? idx_s : grant_s;
      found_s = found_s || hit_s;
    end
    accept_s             = found_s && (state_q == RUN) && !bus.clr;
    req_ready_s          = '0;
    req_ready_s[grant_s] = accept_s;
  end

  assign old_s = table_q[ex_ch_q];

  upd_alu u_alu_avg (.seeded(old_s.seeded), .g_old(old_s.avg),      .s(ex_avg_q), .g_new(new_avg_s));
  upd_alu u_alu_var (.seeded(old_s.seeded), .g_old(old_s.variance), .s(ex_var_q), .g_new(new_var_s));

  // Pointer advance, EX capture, done capture and the registered read port.
  always_comb begin
    ptr_d        = ptr_q;
    ex_valid_d   = accept_s;
    ex_req_d     = ex_req_q;
    ex_ch_d      = ex_ch_q;
    ex_avg_d     = ex_avg_q;
    ex_var_d     = ex_var_q;
    done_valid_d = ex_valid_q;
    done_req_d   = done_req_q;
    done_ch_d    = done_ch_q;
    done_avg_d   = done_avg_q;
    done_var_d   = done_var_q;
    rd_avg_d     = table_q[bus.rd_ch].avg;
    rd_var_d     = table_q[bus.rd_ch].variance;
    if (accept_s) begin
      ptr_d    = REQ_WIDTH'((int'(grant_s) + 1) % NUM_REQ);
      ex_req_d = grant_s;
      ex_ch_d  = bus.req_ch[grant_s*CH_WIDTH +: CH_WIDTH];
      ex_avg_d = bus.req_avg[grant_s*DATA_WIDTH +: DATA_WIDTH];
      ex_var_d = bus.req_var[grant_s*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      ptr_d = ptr_q;
    end
    if (ex_valid_q) begin
      done_req_d = ex_req_q;
      done_ch_d  = ex_ch_q;
      done_avg_d = new_avg_s;
      done_var_d = new_var_s;
    end else begin
      done_req_d = done_req_q;
    end
  end

  // Table write-back of the EX update, or a full wipe during CLEAR.
  always_comb begin
    table_d = table_q;
    if (state_q == CLEAR) begin
      for (int c = 0; c < NUM_CH; c++) begin
        table_d[c] = '0;
      end
    end else if (ex_valid_q) begin
      table_d[ex_ch_q] = '{avg: new_avg_s, variance: new_var_s, seeded: 1'b1};
    end else begin
      table_d = table_q;
    end
  end

  // Clear sequencing: let an in-flight update land before wiping the table.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN: begin
        if (bus.clr) begin
          state_d = ex_valid_q ? DRAIN : CLEAR;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN:   state_d = CLEAR;
      CLEAR:   state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      ptr_q        <= '0;
      ex_valid_q   <= 1'b0;
      ex_req_q     <= '0;
      ex_ch_q      <= '0;
      ex_avg_q     <= '0;
      ex_var_q     <= '0;
      done_valid_q <= 1'b0;
      done_req_q   <= '0;
      done_ch_q    <= '0;
      done_avg_q   <= '0;
      done_var_q   <= '0;
      rd_avg_q     <= '0;
      rd_var_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        table_q[c] <= '0;
      end
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      ex_valid_q   <= ex_valid_d;
      ex_req_q     <= ex_req_d;
      ex_ch_q      <= ex_ch_d;
      ex_avg_q     <= ex_avg_d;
      ex_var_q     <= ex_var_d;
      done_valid_q <= done_valid_d;
      done_req_q   <= done_req_d;
      done_ch_q    <= done_ch_d;
      done_avg_q   <= done_avg_d;
      done_var_q   <= done_var_d;
      rd_avg_q     <= rd_avg_d;
      rd_var_q     <= rd_var_d;
      table_q      <= table_d;
    end
  end

  assign bus.req_ready  = req_ready_s;
  assign bus.busy       = (state_q != RUN);
  assign bus.done_valid = done_valid_q;
  assign bus.done_req   = done_req_q;
  assign bus.done_ch    = done_ch_q;
  assign bus.done_avg   = done_avg_q;
  assign bus.done_var   = done_var_q;
  assign bus.rd_avg     = rd_avg_q;
  assign bus.rd_var     = rd_var_q;

endmodule
